// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared types and helpers for the sequential radix-2 restoring
//               divider family.
//               - div_state_t : controller state encoding (IDLE/BUSY/DONE)
//               - cnt_width() : width of the iteration counter for a given
//                               dividend width
// Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must hold DW-1; never let it collapse to zero width.
    function automatic int unsigned cnt_width(input int unsigned dw);
        int unsigned w;
        w = $clog2(dw);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder, trial-subtracts the
//               divisor and keeps the difference when it does not underflow.
// Ports       : prem      [VW-1:0] in  - current partial remainder (< divisor)
//               shift_bit          in  - next dividend bit, MSB first
//               divisor   [VW-1:0] in  - divisor (nonzero in normal use)
//               prem_next [VW:0]   out - next partial remainder
//               qbit               out - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int VW = 16
) (
    input  logic [VW-1:0] prem,
    input  logic          shift_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   prem_next,
    output logic          qbit
);

    // The remainder entering a step is below the divisor, so the trial value
    // always fits in VW+1 bits.
    logic [VW:0] w_trial;
    logic [VW:0] w_diff;

    assign w_trial   = {prem, shift_bit};
    assign w_diff    = w_trial - {1'b0, divisor};
    assign qbit      = (w_trial >= {1'b0, divisor});
    assign prem_next = qbit ? w_diff : w_trial;

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned integer divider, radix-2 restoring, one
//               quotient bit per clock. One operation in flight; results are
//               held until the consumer accepts them. Divide-by-zero returns
//               all-ones quotient, remainder = dividend[VW-1:0], dbz = 1.
// Ports       : clk, rst (sync, active high)
//               in_valid/in_ready   - operand handshake
//               dividend [DW-1:0], divisor [VW-1:0]
//               out_valid/out_ready - result handshake
//               quotient [DW-1:0], remainder [VW-1:0], dbz
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = 16,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int unsigned CW = cnt_width(DW);
    localparam logic [CW-1:0] c_count_init = CW'(DW - 1);

    div_state_t    r_state;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_shift;     // dividend bits shifting out, quotient bits in
    logic [VW-1:0] r_divisor;
    logic [VW:0]   r_prem;
    logic [DW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic          r_dbz;

    logic [VW:0]   w_prem_next;
    logic          w_qbit;
    logic [DW-1:0] w_shift_next;

    div_step #(
        .VW (VW)
    ) u_step (
        .prem      (r_prem[VW-1:0]),
        .shift_bit (r_shift[DW-1]),
        .divisor   (r_divisor),
        .prem_next (w_prem_next),
        .qbit      (w_qbit)
    );

    assign w_shift_next = {r_shift[DW-2:0], w_qbit};

    // Partial remainder stays below the divisor, so its top bit is always
    // zero; it is carried only to keep the register at trial width.
    logic w_unused_msbs;
    assign w_unused_msbs = ^{r_prem[VW], w_prem_next[VW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_divisor   <= '0;
            r_prem      <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift   <= dividend;
                        r_divisor <= divisor;
                        r_prem    <= '0;
                        r_count   <= c_count_init;
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend[VW-1:0];
                            r_dbz       <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_shift <= w_shift_next;
                    r_prem  <= w_prem_next;
                    if (r_count == '0) begin
                        // Final step: publish the completed result directly so
                        // outputs are valid the same cycle DONE is entered.
                        r_quotient  <= w_shift_next;
                        r_remainder <= w_prem_next[VW-1:0];
                        r_state     <= DONE;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dbz       = r_dbz;

endmodule : seq_divider
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle unsigned integer divider, radix-2 restoring, one quotient bit per clock.
- Successor to the fixed divide-by-3 combinational block: generic dividend width, runtime divisor, valid/ready handshakes, divide-by-zero reporting.
- Sits between arithmetic datapath stages that tolerate variable latency and need bounded timing, unlike the unbounded subtract loop.

Parameters:
- DW, 16, dividend and quotient width in bits (>= 2).
- VW, 16, divisor and remainder width in bits (1..DW).
- CW, $clog2(DW), iteration counter width (derived, not overridable).

Ports:
- clk, input, 1, sole clock, rising-edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, divider can accept operands.
- dividend, input, DW, unsigned dividend.
- divisor, input, VW, unsigned divisor.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- quotient, output, DW, unsigned quotient.
- remainder, output, VW, unsigned remainder.
- dbz, output, 1, divide-by-zero flag, qualified by out_valid.

Behaviour:
- Reset (rst high at a clk edge, any state):
  - State becomes IDLE. Any in-flight operation is discarded.
  - Next cycle: in_ready=1, out_valid=0, quotient=0, remainder=0, dbz=0.
  - Internal counter and working registers are cleared.
- State machine: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE), driven from the registered state with no combinational path from in_valid.
  - out_valid = (state==DONE).
- IDLE:
  - Accept when in_valid && in_ready. Capture dividend into the shift register, divisor into the divisor register, clear the partial remainder (VW+1 bits), set count=DW-1.
  - If divisor==0: go straight to DONE with quotient=all ones, remainder=dividend[VW-1:0], dbz=1.
  - Otherwise go to BUSY.
- BUSY (one step per cycle):
  - Form trial = {partial_rem[VW-1:0], msb of shift register}, then shift the register left.
  - If trial >= divisor: partial_rem = trial - divisor and insert 1 as the quotient LSB. Otherwise partial_rem = trial and insert 0.
  - At count==0, the step completes and the state moves to DONE. Otherwise count decrements.
- Latency and throughput:
  - Accept edge in cycle 0 gives out_valid in cycle DW+1 (normal) or cycle 1 (dbz).
  - One operation in flight. Throughput is at best one result every DW+2 cycles.
- DONE:
  - quotient, remainder and dbz are registered and held stable while out_valid=1 and out_ready=0, for arbitrarily long.
  - on out_valid && out_ready, move to IDLE. out_valid drops the next cycle. Output values may stay stale after the transfer.
- Width rules:
  - Results are exact for all unsigned operand pairs. No overflow is possible.
  - remainder < divisor always, and dividend == quotient*divisor + remainder when dbz=0.
- Boundaries:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
  - dividend=0 gives quotient=0, remainder=0 via the normal path with full latency.
  - in_valid asserted during BUSY or DONE is ignored and its operands are not sampled. The producer must hold them until in_ready.
  - out_ready asserted while not DONE has no effect.
- Operands are sampled only on the accept edge. Changes afterwards do not affect the result.

Decomposition:
- Package seq_divider_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, BUSY, DONE}.
  - Localparam helper function for counter width.
- Sub-module div_step (combinational, parametrised by VW):
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once in the BUSY datapath, and reusable later by an unrolled or pipelined divider variant.

Test Plan (DW=16, VW=16):
- Directed operands:
  - dividend=100, divisor=3, accept in cycle 0 -> out_valid in cycle 17, quotient=33, remainder=1, dbz=0.
  - dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0. Then dividend=5, divisor=7 -> quotient=0, remainder=5.
- Divide by zero: dividend=1234, divisor=0 -> out_valid in cycle 1, quotient=0xFFFF, remainder=1234, dbz=1.
- Backpressure: out_ready held 0 for 10 cycles after out_valid.
  - Outputs stay constant, in_ready=0 and in_valid is ignored throughout.
  - Releasing out_ready gives one transfer, then in_ready=1 the next cycle.
- Reset mid-BUSY: rst asserted in cycle 8 of a 100/3 operation.
  - Next cycle: IDLE, in_ready=1, all outputs 0, no stale out_valid.
  - A following 200/7 returns quotient=28, remainder=4.
- Random self-check: 10k random operand pairs with random in_valid/out_ready gaps.
  - quotient*divisor+remainder==dividend and remainder<divisor for every nonzero divisor.
